// File: rtl/lagd_addr_map_ctrl.sv
`default_nettype none
// =============================================================================
// lagd_addr_map_ctrl: runtime-programmable address map (shadow/active tables,
// sequential range/overlap checker, registered decode). Rev 1.0
// =============================================================================
module lagd_addr_map_ctrl #(
  parameter int unsigned NumRules   = 8,
  parameter int unsigned AddrWidth  = 48,
  parameter int unsigned IdxWidth   = 8,
  parameter logic [IdxWidth-1:0] DefaultIdx = '0,
  localparam int unsigned RuleWidth = $clog2(NumRules)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cfg_valid_i,
  output logic                 cfg_ready_o,
  input  logic [RuleWidth-1:0] cfg_rule_i,
  input  logic [AddrWidth-1:0] cfg_start_i,
  input  logic [AddrWidth-1:0] cfg_end_i,
  input  logic [IdxWidth-1:0]  cfg_idx_i,
  input  logic                 cfg_en_i,
  input  logic                 commit_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [1:0]           err_code_o,
  output logic [RuleWidth-1:0] err_rule_o,
  input  logic                 dec_valid_i,
  input  logic [AddrWidth-1:0] dec_addr_i,
  output logic                 dec_valid_o,
  output logic                 dec_hit_o,
  output logic [IdxWidth-1:0]  dec_idx_o
);

  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StChkRange = 2'd1;
  localparam logic [1:0] StChkOvl   = 2'd2;
  localparam logic [1:0] StApply    = 2'd3;

  localparam logic [RuleWidth-1:0] LastRule  = RuleWidth'(NumRules - 1);
  localparam logic [RuleWidth-1:0] LastPairI = RuleWidth'(NumRules - 2);

  localparam logic [1:0] ErrNone  = 2'd0;
  localparam logic [1:0] ErrRange = 2'd1;
  localparam logic [1:0] ErrOvl   = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [RuleWidth-1:0] ci_q, ci_d, cj_q, cj_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic [1:0]           code_q, code_d;
  logic [RuleWidth-1:0] erule_q, erule_d;

  logic [AddrWidth-1:0] sh_start_q  [NumRules];
  logic [AddrWidth-1:0] sh_end_q    [NumRules];
  logic [IdxWidth-1:0]  sh_idx_q    [NumRules];
  logic                 sh_en_q     [NumRules];
  logic [AddrWidth-1:0] act_start_q [NumRules];
  logic [AddrWidth-1:0] act_end_q   [NumRules];
  logic [IdxWidth-1:0]  act_idx_q   [NumRules];
  logic                 act_en_q    [NumRules];

  logic                 dec_valid_q, dec_hit_q;
  logic [IdxWidth-1:0]  dec_idx_q;
  logic                 dec_hit_d;
  logic [IdxWidth-1:0]  dec_idx_d;
  logic [NumRules-1:0]  match;

  logic cfg_hs, rule_ok, range_bad, ovl_bad;

  assign cfg_hs  = cfg_valid_i & cfg_ready_o;
  assign rule_ok = (32'(cfg_rule_i) < NumRules);

  assign range_bad = sh_en_q[ci_q] && (sh_start_q[ci_q] > sh_end_q[ci_q]);
  // Closed intervals: a shared boundary address is an overlap.
  assign ovl_bad   = sh_en_q[ci_q] && sh_en_q[cj_q] &&
                     (sh_start_q[ci_q] <= sh_end_q[cj_q]) &&
                     (sh_start_q[cj_q] <= sh_end_q[ci_q]);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ci_d    = ci_q;
    cj_d    = cj_q;
    done_d  = 1'b0;
    err_d   = err_q;
    code_d  = code_q;
    erule_d = erule_q;
    case (state_q)
      StIdle: begin
        if (commit_i) begin
          state_d = StChkRange;
          ci_d    = '0;
          err_d   = 1'b0;
          code_d  = ErrNone;
          erule_d = '0;
        end
      end
      StChkRange: begin
        if (range_bad) begin
          state_d = StIdle;
          done_d  = 1'b1;
          err_d   = 1'b1;
          code_d  = ErrRange;
          erule_d = ci_q;
        end else if (ci_q == LastRule) begin
          state_d = StChkOvl;
          ci_d    = '0;
          cj_d    = RuleWidth'(1);
        end else begin
          ci_d = ci_q + RuleWidth'(1);
        end
      end
      StChkOvl: begin
        if (ovl_bad) begin
          state_d = StIdle;
          done_d  = 1'b1;
          err_d   = 1'b1;
          code_d  = ErrOvl;
          erule_d = ci_q;
        end else if (cj_q == LastRule) begin
          if (ci_q == LastPairI) begin
            state_d = StApply;
          end else begin
            ci_d = ci_q + RuleWidth'(1);
            cj_d = ci_q + RuleWidth'(2);
          end
        end else begin
          cj_d = cj_q + RuleWidth'(1);
        end
      end
      StApply: begin
        state_d = StIdle;
        done_d  = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy_o      = (state_q != StIdle);
    cfg_ready_o = (state_q == StIdle);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ci_q    <= '0;
      cj_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= ErrNone;
      erule_q <= '0;
    end else begin
      ci_q    <= ci_d;
      cj_q    <= cj_d;
      done_q  <= done_d;
      err_q   <= err_d;
      code_q  <= code_d;
      erule_q <= erule_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < int'(NumRules); k++) begin
        sh_start_q[k]  <= '0;
        sh_end_q[k]    <= '0;
        sh_idx_q[k]    <= '0;
        sh_en_q[k]     <= 1'b0;
        act_start_q[k] <= '0;
        act_end_q[k]   <= '0;
        act_idx_q[k]   <= '0;
        act_en_q[k]    <= 1'b0;
      end
    end else begin
      if (cfg_hs && rule_ok) begin
        sh_start_q[cfg_rule_i] <= cfg_start_i;
        sh_end_q[cfg_rule_i]   <= cfg_end_i;
        sh_idx_q[cfg_rule_i]   <= cfg_idx_i;
        sh_en_q[cfg_rule_i]    <= cfg_en_i;
      end
      if (state_q == StApply) begin
        for (int k = 0; k < int'(NumRules); k++) begin
          act_start_q[k] <= sh_start_q[k];
          act_end_q[k]   <= sh_end_q[k];
          act_idx_q[k]   <= sh_idx_q[k];
          act_en_q[k]    <= sh_en_q[k];
        end
      end
    end
  end

  for (genvar g = 0; g < int'(NumRules); g++) begin : g_match
    assign match[g] = act_en_q[g] && (act_start_q[g] <= dec_addr_i) &&
                      (dec_addr_i <= act_end_q[g]);
  end

  // Scan high to low so the lowest matching rule number is the one that sticks.
  always_comb begin
    dec_hit_d = |match;
    dec_idx_d = DefaultIdx;
    for (int k = int'(NumRules) - 1; k >= 0; k--) begin
      if (match[k]) dec_idx_d = act_idx_q[k];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dec_valid_q <= 1'b0;
      dec_hit_q   <= 1'b0;
      dec_idx_q   <= DefaultIdx;
    end else begin
      dec_valid_q <= dec_valid_i;
      if (dec_valid_i) begin
        dec_hit_q <= dec_hit_d;
        dec_idx_q <= dec_idx_d;
      end
    end
  end

  assign done_o      = done_q;
  assign err_o       = err_q;
  assign err_code_o  = code_q;
  assign err_rule_o  = erule_q;
  assign dec_valid_o = dec_valid_q;
  assign dec_hit_o   = dec_hit_q;
  assign dec_idx_o   = dec_idx_q;

endmodule
`default_nettype wire
